// File: rtl/divu_hilo_sequencer.sv
// divu_hilo_sequencer
// Decodes the funct field of the instruction in decode. It drives the
// registered ALU op and the result-mux select. It also runs the multi-cycle
// DIVU sequence: start the divider, wait DIV_CYCLES clocks, then write HI/LO.
// While a divide is in flight, any DIVU/MFHI/MFLO is held off with stall.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   funct[5:0]   instruction funct field
//   funct_valid  funct carries a live instruction this cycle
//   alu_op[2:0]  registered ALU operation code
//   mux_sel[1:0] registered result select: 0 ALU, 1 shifter, 2 HI, 3 LO
//   div_start    one-cycle start pulse to the divider
//   busy         divide in flight (RUN or WRITE)
//   hilo_we      one-cycle HI/LO write enable
//   stall        combinational; the presented instruction is not accepted
//   illegal      registered one-cycle pulse for an unknown funct
module divu_hilo_sequencer #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] funct,
  input  logic       funct_valid,
  output logic [2:0] alu_op,
  output logic [1:0] mux_sel,
  output logic       div_start,
  output logic       busy,
  output logic       hilo_we,
  output logic       stall,
  output logic       illegal
);

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLT  = 6'd42;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  logic [5:0] dec_s;       // {illegal, alu_op[2:0], mux_sel[1:0]}
  logic       hilo_use_s;  // instruction needs the divider or HI/LO
  logic       accept_s;
  logic       is_divu_s;

  // Decode table: returns {illegal, alu_op, mux_sel}.
  function automatic logic [5:0] decode(input logic [5:0] f);
    logic [5:0] d;
    case (f)
      F_ADD:   d = {1'b0, 3'b010, 2'd0};
      F_SUB:   d = {1'b0, 3'b110, 2'd0};
      F_AND:   d = {1'b0, 3'b000, 2'd0};
      F_OR:    d = {1'b0, 3'b001, 2'd0};
      F_SLT:   d = {1'b0, 3'b111, 2'd0};
      F_SLL:   d = {1'b0, 3'b011, 2'd1};
      F_MFHI:  d = {1'b0, 3'b000, 2'd2};
      F_MFLO:  d = {1'b0, 3'b000, 2'd3};
      F_DIVU:  d = {1'b0, 3'b000, 2'd0};
      default: d = {1'b1, 3'b000, 2'd0};
    endcase
    return d;
  endfunction

  // Decode and acceptance; ALU/shift ops never stall, even mid-divide.
  always_comb begin
    dec_s      = decode(funct);
    is_divu_s  = (funct == F_DIVU);
    hilo_use_s = is_divu_s || (funct == F_MFHI) || (funct == F_MFLO);
    if (funct_valid && busy && hilo_use_s) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
    accept_s = funct_valid && !stall;
  end

  // WRITE counts as busy so a new DIVU/MFHI/MFLO waits for the HI/LO update.
  assign busy = (state_r != IDLE);

  // Decode output registers and the divide sequencing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      alu_op    <= 3'b000;
      mux_sel   <= 2'd0;
      illegal   <= 1'b0;
      div_start <= 1'b0;
      hilo_we   <= 1'b0;
    end else begin
      // Pulse outputs default low so each lasts exactly one cycle.
      div_start <= 1'b0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;

      if (accept_s) begin
        alu_op  <= dec_s[4:2];
        mux_sel <= dec_s[1:0];
        illegal <= dec_s[5];
      end

      case (state_r)
        IDLE: begin
          // A DIVU is only accepted here, since busy stalls it elsewhere.
          if (accept_s && is_divu_s) begin
            state_r   <= RUN;
            cnt_r     <= '0;
            div_start <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= WRITE;
            hilo_we <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WRITE: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_hilo_sequencer.sv
// Self-checking bench for divu_hilo_sequencer. It uses a DIV_CYCLES=32
// instance for the main scenarios and a DIV_CYCLES=4 instance for the short
// regression. Inputs change 1 time unit after the rising edge. Outputs are
// sampled 1 time unit after that. "Cycle c" is the period after edge c.
module tb_divu_hilo_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] funct = 6'd0;
  logic       funct_valid = 1'b0;
  logic [2:0] alu_op;
  logic [1:0] mux_sel;
  logic       div_start, busy, hilo_we, stall, illegal;

  logic [5:0] funct4 = 6'd0;
  logic       valid4 = 1'b0;
  logic [2:0] alu_op4;
  logic [1:0] mux_sel4;
  logic       div_start4, busy4, hilo_we4, stall4, illegal4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divu_hilo_sequencer #(.DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .funct(funct), .funct_valid(funct_valid),
    .alu_op(alu_op), .mux_sel(mux_sel), .div_start(div_start), .busy(busy),
    .hilo_we(hilo_we), .stall(stall), .illegal(illegal)
  );

  divu_hilo_sequencer #(.DIV_CYCLES(4), .CNT_W(6)) dut4 (
    .clk(clk), .rst(rst), .funct(funct4), .funct_valid(valid4),
    .alu_op(alu_op4), .mux_sel(mux_sel4), .div_start(div_start4), .busy(busy4),
    .hilo_we(hilo_we4), .stall(stall4), .illegal(illegal4)
  );

  typedef struct {
    logic [5:0] f;
    logic [2:0] alu;
    logic [1:0] mux;
    logic       ill;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    funct_valid = 1'b0;
    valid4 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0] = '{6'd32, 3'b010, 2'd0, 1'b0};
    tbl[1] = '{6'd34, 3'b110, 2'd0, 1'b0};
    tbl[2] = '{6'd36, 3'b000, 2'd0, 1'b0};
    tbl[3] = '{6'd37, 3'b001, 2'd0, 1'b0};
    tbl[4] = '{6'd42, 3'b111, 2'd0, 1'b0};
    tbl[5] = '{6'd0,  3'b011, 2'd1, 1'b0};
    tbl[6] = '{6'd16, 3'b000, 2'd2, 1'b0};
    tbl[7] = '{6'd18, 3'b000, 2'd3, 1'b0};
    tbl[8] = '{6'd63, 3'b000, 2'd0, 1'b1};
    tbl[9] = '{6'd37, 3'b001, 2'd0, 1'b0};

    // Reset state
    #2;
    check("rst_alu_op", 0, 32'(alu_op), 32'd0);
    check("rst_mux_sel", 0, 32'(mux_sel), 32'd0);
    check("rst_div_start", 0, 32'(div_start), 32'd0);
    check("rst_hilo_we", 0, 32'(hilo_we), 32'd0);
    check("rst_illegal", 0, 32'(illegal), 32'd0);
    check("rst_busy", 0, 32'(busy), 32'd0);
    do_reset();

    // Decode table, one instruction per cycle
    for (int i = 0; i < 10; i++) begin
      funct = tbl[i].f;
      funct_valid = 1'b1;
      #1;
      check("tbl_stall", i, 32'(stall), 32'd0);
      tick();
      check($sformatf("tbl_alu_op[%0d]", i), i, 32'(alu_op), 32'(tbl[i].alu));
      check($sformatf("tbl_mux_sel[%0d]", i), i, 32'(mux_sel), 32'(tbl[i].mux));
      check($sformatf("tbl_illegal[%0d]", i), i, 32'(illegal), 32'(tbl[i].ill));
    end
    // funct_valid=0: decode outputs hold, illegal stays low
    funct = 6'd34;
    funct_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_alu_op", i, 32'(alu_op), 32'b001);
      check("hold_mux_sel", i, 32'(mux_sel), 32'd0);
      check("hold_illegal", i, 32'(illegal), 32'd0);
    end

    // DIVU timing plus MFHI held from cycle 5
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      if (c == 0) begin
        funct = 6'd27; funct_valid = 1'b1;
      end else if (c == 1) begin
        funct_valid = 1'b0;
      end else if (c == 5) begin
        funct = 6'd16; funct_valid = 1'b1;
      end else if (c == 35) begin
        funct_valid = 1'b0;
      end
      #1;
      check("div_start", c, 32'(div_start), 32'(c == 1));
      check("busy", c, 32'(busy), 32'(c >= 1 && c <= 33));
      check("hilo_we", c, 32'(hilo_we), 32'(c == 33));
      check("mfhi_stall", c, 32'(stall), 32'(c >= 5 && c <= 33));
      check("mfhi_mux_sel", c, 32'(mux_sel), (c >= 35) ? 32'd2 : 32'd0);
      tick();
    end

    // Second DIVU held during the first; add at cycle 10 goes through
    do_reset();
    for (int c = 0; c <= 37; c++) begin
      if (c == 10) begin
        funct = 6'd32;
      end else if (c >= 35) begin
        funct_valid = 1'b0;
      end else begin
        funct = 6'd27;
      end
      if (c == 0) funct_valid = 1'b1;
      #1;
      check("b2b_stall", c, 32'(stall), 32'(c >= 1 && c <= 33 && c != 10));
      // First hilo_we in 33, idle cycle 34, second start in 35
      check("b2b_div_start", c, 32'(div_start), 32'(c == 1 || c == 35));
      check("b2b_hilo_we", c, 32'(hilo_we), 32'(c == 33));
      check("b2b_busy", c, 32'(busy), 32'((c >= 1 && c <= 33) || c >= 35));
      check("b2b_alu_op", c, 32'(alu_op), (c >= 11 && c <= 34) ? 32'b010 : 32'b000);
      tick();
    end

    // Reset in mid-RUN
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin
        funct = 6'd27; funct_valid = 1'b1;
      end else if (c == 3) begin
        funct = 6'd34; funct_valid = 1'b1;
      end else begin
        funct_valid = 1'b0;
      end
      tick();
    end
    check("pre_rst_busy", 15, 32'(busy), 32'd1);
    check("pre_rst_alu_op", 15, 32'(alu_op), 32'b110);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 15, 32'(busy), 32'd0);
    check("mid_rst_alu_op", 15, 32'(alu_op), 32'd0);
    check("mid_rst_hilo_we", 15, 32'(hilo_we), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 16; c <= 40; c++) begin
      tick();
      check("post_rst_hilo_we", c, 32'(hilo_we), 32'd0);
      check("post_rst_busy", c, 32'(busy), 32'd0);
    end
    // A fresh DIVU still runs the full length
    for (int c = 0; c <= 35; c++) begin
      funct = 6'd27;
      funct_valid = (c == 0);
      #1;
      check("rerun_div_start", c, 32'(div_start), 32'(c == 1));
      check("rerun_busy", c, 32'(busy), 32'(c >= 1 && c <= 33));
      check("rerun_hilo_we", c, 32'(hilo_we), 32'(c == 33));
      tick();
    end

    // DIV_CYCLES=4 instance
    for (int c = 0; c <= 7; c++) begin
      funct4 = 6'd27;
      valid4 = (c == 0);
      #1;
      check("dc4_div_start", c, 32'(div_start4), 32'(c == 1));
      check("dc4_busy", c, 32'(busy4), 32'(c >= 1 && c <= 5));
      check("dc4_hilo_we", c, 32'(hilo_we4), 32'(c == 5));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
